hybrid_switch_sequencer: RTL and testbench



---
 rtl/hybrid_ctrl_pkg.sv | 30 +++
 rtl/dwell_timer.sv | 24 ++
 rtl/hybrid_switch_sequencer.sv | 119 +++++++++++
 tb/tb_hybrid_switch_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hybrid_ctrl_pkg.sv
// Shared types and constants for the hybrid-loop full-bridge sequencer.
// FSM state codes, gate patterns, jump flag bit positions.
package hybrid_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEAD_P = 3'd1,
    ST_POS    = 3'd2,
    ST_DEAD_N = 3'd3,
    ST_NEG    = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  // gate bits: [0] Q1 A-high, [1] Q2 A-low, [2] Q3 B-high, [3] Q4 B-low
  localparam logic [3:0] GATE_OFF = 4'b0000;
  localparam logic [3:0] GATE_POS = 4'b1001;
  localparam logic [3:0] GATE_NEG = 4'b0110;

  localparam int JUMP_POS = 0;
  localparam int JUMP_NEG = 1;

  function automatic logic [3:0] gate_of(state_t s);
    case (s)
      ST_POS:  return GATE_POS;
      ST_NEG:  return GATE_NEG;
      default: return GATE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Clear/enable counter that saturates at MAX.
// Ports: clk, rst (async high), clr, en -> count.
module dwell_timer #(
  parameter int CNT_W = 16,
  parameter int MAX   = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != CNT_W'(MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hybrid_switch_sequencer.sv
// Full-bridge gate sequencer: dead time, min/max dwell, fault latch.
// Ports: i_clk, i_reset, i_enable, i_jump[1:0], i_fault, i_fault_clr ->
//        o_gate[3:0], o_sigma, o_state[2:0], o_fault, o_timeout.
module hybrid_switch_sequencer #(
  parameter int DEAD_TIME = 10,
  parameter int MIN_DWELL = 20,
  parameter int MAX_DWELL = 2000,
  parameter int CNT_W     = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [1:0] i_jump,
  input  logic       i_fault,
  input  logic       i_fault_clr,
  output logic [3:0] o_gate,
  output logic       o_sigma,
  output logic [2:0] o_state,
  output logic       o_fault,
  output logic       o_timeout
);
  import hybrid_ctrl_pkg::*;

  state_t           state;
  state_t           nxt;
  logic             tmo_nxt;
  logic [CNT_W-1:0] dead_cnt;
  logic [CNT_W-1:0] dwell;
  logic             in_dead;
  logic             in_cond;
  logic             moving;

  assign in_dead = (state == ST_DEAD_P) || (state == ST_DEAD_N);
  assign in_cond = (state == ST_POS) || (state == ST_NEG);
  // every state entry restarts both timers from zero
  assign moving  = (nxt != state);

  dwell_timer #(.CNT_W(CNT_W), .MAX(DEAD_TIME)) u_dead (
    .clk   (i_clk),
    .rst   (i_reset),
    .clr   (moving),
    .en    (in_dead),
    .count (dead_cnt)
  );

  dwell_timer #(.CNT_W(CNT_W), .MAX(MAX_DWELL)) u_dwell (
    .clk   (i_clk),
    .rst   (i_reset),
    .clr   (moving),
    .en    (in_cond),
    .count (dwell)
  );

  always_comb begin
    nxt     = state;
    tmo_nxt = 1'b0;
    if (i_fault) begin
      nxt = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_enable && !o_fault) nxt = ST_DEAD_P;
        end
        ST_DEAD_P: begin
          if (!i_enable) nxt = ST_IDLE;
          else if (dead_cnt == CNT_W'(DEAD_TIME - 1)) nxt = ST_POS;
        end
        ST_DEAD_N: begin
          if (!i_enable) nxt = ST_IDLE;
          else if (dead_cnt == CNT_W'(DEAD_TIME - 1)) nxt = ST_NEG;
        end
        ST_POS: begin
          if (!i_enable) begin
            nxt = ST_IDLE;
          end else if (i_jump[JUMP_NEG] && dwell >= CNT_W'(MIN_DWELL)) begin
            nxt = ST_DEAD_N;
          end else if (dwell == CNT_W'(MAX_DWELL - 1)) begin
            nxt     = ST_DEAD_N;
            tmo_nxt = 1'b1;
          end
        end
        ST_NEG: begin
          if (!i_enable) begin
            nxt = ST_IDLE;
          end else if (i_jump[JUMP_POS] && dwell >= CNT_W'(MIN_DWELL)) begin
            nxt = ST_DEAD_P;
          end else if (dwell == CNT_W'(MAX_DWELL - 1)) begin
            nxt     = ST_DEAD_P;
            tmo_nxt = 1'b1;
          end
        end
        ST_FAULT: begin
          if (i_fault_clr) nxt = ST_IDLE;
        end
        default: nxt = ST_FAULT;
      endcase
    end
  end

  // outputs decoded from the next state so gates move with the state
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      o_gate    <= GATE_OFF;
      o_sigma   <= 1'b0;
      o_fault   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= nxt;
      o_gate    <= gate_of(nxt);
      o_sigma   <= (nxt == ST_POS);
      o_fault   <= (nxt == ST_FAULT);
      o_timeout <= tmo_nxt;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_hybrid_switch_sequencer.sv
// Bench for hybrid_switch_sequencer with DEAD=4, MIN=8, MAX=32.
// Vector table + expected-value queue, then async reset corners.
module tb_hybrid_switch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] jump;
  logic       flt;
  logic       clr;
  logic [3:0] gate;
  logic       sigma;
  logic [2:0] st;
  logic       fo;
  logic       tmo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hybrid_switch_sequencer #(
    .DEAD_TIME (4),
    .MIN_DWELL (8),
    .MAX_DWELL (32),
    .CNT_W     (16)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_enable    (en),
    .i_jump      (jump),
    .i_fault     (flt),
    .i_fault_clr (clr),
    .o_gate      (gate),
    .o_sigma     (sigma),
    .o_state     (st),
    .o_fault     (fo),
    .o_timeout   (tmo)
  );

  typedef struct {
    logic       en;
    logic [1:0] jump;
    logic       flt;
    logic       clr;
    int         reps;
    logic [2:0] st;
    logic       fo;
    logic       tmo;
  } vec_t;

  typedef struct {
    int         row;
    logic [9:0] v;
  } exp_t;

  vec_t tbl[$];
  exp_t q[$];

  function automatic logic [3:0] pat(logic [2:0] s);
    if (s == 3'd2) return 4'b1001;
    if (s == 3'd4) return 4'b0110;
    return 4'b0000;
  endfunction

  function automatic logic [9:0] pack_exp(vec_t r);
    return {pat(r.st), r.st, (r.st == 3'd2), r.fo, r.tmo};
  endfunction

  task automatic row(input logic e, input logic [1:0] j, input logic f,
                     input logic c, input int n, input logic [2:0] s,
                     input logic o, input logic t);
    vec_t r;
    r.en = e; r.jump = j; r.flt = f; r.clr = c;
    r.reps = n; r.st = s; r.fo = o; r.tmo = t;
    tbl.push_back(r);
  endtask

  task automatic cmp(input string nm, input logic [9:0] got,
                     input logic [9:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got gate/st/sig/flt/tmo=%b want=%b", nm, got, want);
    end
  endtask

  // shoot-through guard on every cycle outside reset
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((gate[0] & gate[1]) | (gate[2] & gate[3])) begin
        failures++;
        $display("FAIL shoot_through got gate=%b want no leg pair", gate);
      end
    end
  end

  initial begin
    exp_t e;
    int   t_first;
    int   t_second;
    bit   seen;

    rst = 1'b1; en = 1'b0; jump = 2'b00; flt = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset", {gate, st, sigma, fo, tmo}, 10'd0);
    rst = 1'b0;

    // en jump flt clr reps state o_fault o_timeout
    row(0, 2'b00, 0, 0, 2,  3'd0, 0, 0);
    row(1, 2'b00, 0, 0, 4,  3'd1, 0, 0);
    row(1, 2'b00, 0, 0, 4,  3'd2, 0, 0);
    row(1, 2'b10, 0, 0, 1,  3'd2, 0, 0);
    row(1, 2'b00, 0, 0, 2,  3'd2, 0, 0);
    row(1, 2'b10, 0, 0, 2,  3'd2, 0, 0);
    row(1, 2'b10, 0, 0, 1,  3'd3, 0, 0);
    row(1, 2'b00, 0, 0, 3,  3'd3, 0, 0);
    row(1, 2'b00, 0, 0, 1,  3'd4, 0, 0);
    row(1, 2'b00, 0, 0, 31, 3'd4, 0, 0);
    row(1, 2'b00, 0, 0, 1,  3'd1, 0, 1);
    row(1, 2'b00, 0, 0, 3,  3'd1, 0, 0);
    row(1, 2'b00, 0, 0, 1,  3'd2, 0, 0);
    row(1, 2'b01, 0, 0, 10, 3'd2, 0, 0);
    row(0, 2'b10, 1, 0, 1,  3'd5, 1, 0);
    row(1, 2'b00, 1, 1, 2,  3'd5, 1, 0);
    row(1, 2'b00, 0, 0, 2,  3'd5, 1, 0);
    row(1, 2'b00, 0, 1, 1,  3'd0, 0, 0);
    row(1, 2'b00, 0, 0, 1,  3'd1, 0, 0);
    row(1, 2'b11, 0, 0, 3,  3'd1, 0, 0);
    row(1, 2'b11, 0, 0, 1,  3'd2, 0, 0);
    row(1, 2'b11, 0, 0, 8,  3'd2, 0, 0);
    row(1, 2'b11, 0, 0, 1,  3'd3, 0, 0);
    row(1, 2'b11, 0, 0, 3,  3'd3, 0, 0);
    row(1, 2'b11, 0, 0, 1,  3'd4, 0, 0);
    row(1, 2'b11, 0, 0, 8,  3'd4, 0, 0);
    row(1, 2'b11, 0, 0, 1,  3'd1, 0, 0);
    row(1, 2'b00, 0, 0, 3,  3'd1, 0, 0);
    row(1, 2'b00, 0, 0, 1,  3'd2, 0, 0);
    row(1, 2'b10, 0, 0, 8,  3'd2, 0, 0);
    row(1, 2'b10, 0, 0, 1,  3'd3, 0, 0);
    row(1, 2'b00, 0, 0, 3,  3'd3, 0, 0);
    row(1, 2'b00, 0, 0, 1,  3'd4, 0, 0);
    row(1, 2'b00, 0, 0, 2,  3'd4, 0, 0);
    row(0, 2'b00, 0, 0, 1,  3'd0, 0, 0);
    row(0, 2'b00, 0, 0, 1,  3'd0, 0, 0);
    row(1, 2'b00, 0, 0, 1,  3'd1, 0, 0);
    row(1, 2'b00, 0, 0, 3,  3'd1, 0, 0);
    row(1, 2'b00, 0, 0, 1,  3'd2, 0, 0);

    for (int r = 0; r < tbl.size(); r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        en = tbl[r].en; jump = tbl[r].jump;
        flt = tbl[r].flt; clr = tbl[r].clr;
        e.row = r;
        e.v   = pack_exp(tbl[r]);
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        cmp($sformatf("row%0d", e.row), {gate, st, sigma, fo, tmo}, e.v);
      end
    end

    // async reset while conducting: gates drop with no clock edge
    #2 rst = 1'b1;
    #1 cmp("async_pos", {gate, st, sigma, fo, tmo}, 10'd0);
    en = 1'b0; jump = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // free-running timeout period: 2*(32+4)/2 between pulses
    t_first = -1; t_second = -1;
    for (int c = 0; c < 200 && t_second < 0; c++) begin
      @(posedge clk);
      #1;
      if (tmo) begin
        if (t_first < 0) t_first = c;
        else t_second = c;
      end
    end
    cmp("tmo_seen", {9'd0, t_second >= 0}, 10'd1);
    cmp("tmo_period", 10'(t_second - t_first), 10'd36);

    // async reset mid DEAD_N
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (st == 3'd3) seen = 1'b1;
    end
    cmp("deadn_seen", {9'd0, seen}, 10'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 cmp("async_deadn", {gate, st, sigma, fo, tmo}, 10'd0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    @(posedge clk);
    #1 cmp("post_reset_idle", {gate, st, sigma, fo, tmo}, 10'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
